// File: rtl/prog_instruction_memory.sv
// Loadable instruction memory: registered fetch port in RUN, sequential word loader in LOAD.
// Optional per-word even parity when IMEM_PARITY_EN is defined.
module prog_instruction_memory #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DEPTH      = 32,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = 8'hC0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] Read_Address,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  output logic                  addr_fault,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  input  logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  parity_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic {RUN, LOAD} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         ra;
  logic                  wr_en, last_wr, fetch, in_range;

  // The write pointer is the low part of load_count; LOAD exits before it could pass DEPTH-1.
  assign ptr      = load_count[IW-1:0];
  assign ra       = Read_Address[IW-1:0];
  assign wr_en    = (state == LOAD) && load_valid;
  assign last_wr  = (load_count == CW'(DEPTH - 1));
  assign fetch    = (state == RUN) && rd_en;
  assign in_range = ({1'b0, Read_Address} < CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    case (state)
      RUN:  if (load_start) state_nxt = LOAD;
      LOAD: begin
        load_ready = 1'b1;
        if (load_done || (load_valid && last_wr)) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               load_count <= '0;
    else if ((state == RUN) && load_start)    load_count <= '0;
    else if (wr_en)                           load_count <= load_count + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= FILL_WORD;
    end else if (wr_en) begin
      mem[ptr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= FILL_WORD;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
    end else if (fetch) begin
      instruction <= in_range ? mem[ra] : FILL_WORD;
      instr_valid <= 1'b1;
      addr_fault  <= !in_range;
    end else begin
      instr_valid <= 1'b0;
    end
  end

`ifdef IMEM_PARITY_EN
  logic [DEPTH-1:0] par_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     par_bits      <= {DEPTH{^FILL_WORD}};
    else if (wr_en) par_bits[ptr] <= ^load_data;
  end

  // Out-of-range fetches return the constant fill word, which has no stored parity to compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     parity_err <= 1'b0;
    else if (fetch) parity_err <= in_range && ((^mem[ra]) != par_bits[ra]);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_instruction_memory.sv
// Self-checking bench for prog_instruction_memory: directed scenarios plus randomized
// load/fetch traffic checked against an array model of the program store.
module tb_prog_instruction_memory;

  localparam int DW = 8, AW = 8, DEPTH = 32;
  localparam logic [7:0] FILL = 8'hC0;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] Read_Address = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] instruction;
  logic          instr_valid, addr_fault;
  logic          load_start = 1'b0, load_valid = 1'b0, load_done = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready;
  logic [AW:0]   load_count;
  logic          parity_err;

  int checks = 0, passed = 0;
  logic [7:0] model_mem [DEPTH];

  prog_instruction_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .FILL_WORD(FILL)) dut (
    .clk(clk), .rst_n(rst_n), .Read_Address(Read_Address), .rd_en(rd_en),
    .instruction(instruction), .instr_valid(instr_valid), .addr_fault(addr_fault),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .load_count(load_count),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic fetch(input int a);
    Read_Address = AW'(a); rd_en = 1'b1; step(); rd_en = 1'b0;
  endtask

  function automatic logic [7:0] expect_word(input int a);
    return (a < DEPTH) ? model_mem[a] : FILL;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = FILL;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset();
    step(); step();
    checks++; if (instruction !== FILL) $display("FAIL reset_instr: got %h want %h", instruction, FILL); else passed++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else passed++;
    checks++; if (addr_fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", addr_fault); else passed++;
    checks++; if (load_count !== '0) $display("FAIL reset_count: got %0d want 0", load_count); else passed++;
    checks++; if (load_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", load_ready); else passed++;
    checks++; if (parity_err !== 1'b0) $display("FAIL reset_perr: got %b want 0", parity_err); else passed++;
    rst_n = 1'b1; step();
  endtask

  task automatic test_fill_fetch();
    fetch(5);
    checks++; if (instruction !== FILL) $display("FAIL fill_fetch_data: got %h want %h", instruction, FILL); else passed++;
    checks++; if (instr_valid !== 1'b1) $display("FAIL fill_fetch_valid: got %b want 1", instr_valid); else passed++;
    checks++; if (addr_fault !== 1'b0) $display("FAIL fill_fetch_fault: got %b want 0", addr_fault); else passed++;
    step();
    checks++; if (instr_valid !== 1'b0) $display("FAIL idle_valid: got %b want 0", instr_valid); else passed++;
    checks++; if (instruction !== FILL) $display("FAIL idle_hold: got %h want %h", instruction, FILL); else passed++;
  endtask

  task automatic test_load_short();
    logic [7:0] w [4] = '{8'h49, 8'hC1, 8'h18, 8'hA9};
    load_start = 1'b1; step(); load_start = 1'b0;
    checks++; if (load_ready !== 1'b1) $display("FAIL load_ready_in_load: got %b want 1", load_ready); else passed++;
    checks++; if (load_count !== '0) $display("FAIL load_count_start: got %0d want 0", load_count); else passed++;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = w[i];
      // fetch attempts during LOAD must be ignored
      Read_Address = AW'(i); rd_en = (i == 2);
      step(); model_mem[i] = w[i];
      if (i == 2) begin
        checks++; if (instr_valid !== 1'b0) $display("FAIL fetch_in_load_valid: got %b want 0", instr_valid); else passed++;
        checks++; if (instruction !== FILL) $display("FAIL fetch_in_load_hold: got %h want %h", instruction, FILL); else passed++;
      end
    end
    load_valid = 1'b0; rd_en = 1'b0; load_done = 1'b1; step(); load_done = 1'b0;
    checks++; if (load_ready !== 1'b0) $display("FAIL load_ready_after_done: got %b want 0", load_ready); else passed++;
    checks++; if (load_count !== 9'd4) $display("FAIL load_count_short: got %0d want 4", load_count); else passed++;
    for (int a = 0; a < 4; a++) begin
      fetch(a);
      checks++; if (instruction !== w[a]) $display("FAIL short_fetch_%0d: got %h want %h", a, instruction, w[a]); else passed++;
    end
  endtask

  task automatic test_full_load();
    load_start = 1'b1; step(); load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      load_data = 8'($urandom); step(); model_mem[i] = load_data;
    end
    checks++; if (load_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", load_ready); else passed++;
    checks++; if (load_count !== 9'(DEPTH)) $display("FAIL full_count: got %0d want %0d", load_count, DEPTH); else passed++;
    // extra beat after auto-return to RUN must not be written anywhere
    load_data = ~model_mem[0]; step(); load_valid = 1'b0;
    checks++; if (load_count !== 9'(DEPTH)) $display("FAIL full_count_hold: got %0d want %0d", load_count, DEPTH); else passed++;
    foreach (model_mem[a]) begin
      fetch(a);
      checks++; if (instruction !== model_mem[a]) $display("FAIL full_fetch_%0d: got %h want %h", a, instruction, model_mem[a]); else passed++;
    end
  endtask

  task automatic test_out_of_range();
    int addrs [4] = '{40, 32, 255, 31};
    fetch(40);
    checks++; if (instruction !== FILL) $display("FAIL oor_data: got %h want %h", instruction, FILL); else passed++;
    checks++; if (addr_fault !== 1'b1) $display("FAIL oor_fault: got %b want 1", addr_fault); else passed++;
    checks++; if (instr_valid !== 1'b1) $display("FAIL oor_valid: got %b want 1", instr_valid); else passed++;
    fetch(0);
    checks++; if (addr_fault !== 1'b0) $display("FAIL oor_clear: got %b want 0", addr_fault); else passed++;
    checks++; if (instruction !== model_mem[0]) $display("FAIL oor_next_data: got %h want %h", instruction, model_mem[0]); else passed++;
    foreach (addrs[k]) begin
      fetch(addrs[k]);
      checks++; if (addr_fault !== (addrs[k] >= DEPTH)) $display("FAIL oor_edge_%0d: got %b want %b", addrs[k], addr_fault, addrs[k] >= DEPTH); else passed++;
    end
  endtask

  task automatic test_reset_mid_load();
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = 8'($urandom); step();
    end
    load_valid = 1'b0;
    #2 rst_n = 1'b0; #1;
    model_reset();
    checks++; if (load_count !== '0) $display("FAIL midrst_count: got %0d want 0", load_count); else passed++;
    checks++; if (load_ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", load_ready); else passed++;
    checks++; if (instruction !== FILL) $display("FAIL midrst_instr: got %h want %h", instruction, FILL); else passed++;
    step(); rst_n = 1'b1; step();
    for (int a = 0; a < 4; a++) begin
      fetch(a);
      checks++; if (instruction !== FILL) $display("FAIL midrst_word_%0d: got %h want %h", a, instruction, FILL); else passed++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n = $urandom_range(1, DEPTH);
      bit done_last = 1'($urandom_range(0, 1));
      load_start = 1'b1; step(); load_start = 1'b0;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          load_valid = 1'b0; load_start = 1'($urandom_range(0, 1)); step();
        end
        load_valid = 1'b1; load_data = 8'($urandom);
        load_start = 1'($urandom_range(0, 1));
        load_done  = done_last && (i == n - 1) && (n < DEPTH);
        step(); model_mem[i] = load_data;
      end
      load_valid = 1'b0; load_start = 1'b0; load_done = 1'b0;
      if (n < DEPTH && !done_last) begin
        load_done = 1'b1; step(); load_done = 1'b0;
      end
      checks++; if (load_ready !== 1'b0) $display("FAIL rand_ready_%0d: got %b want 0", it, load_ready); else passed++;
      checks++; if (load_count !== 9'(n)) $display("FAIL rand_count_%0d: got %0d want %0d", it, load_count, n); else passed++;
      for (int f = 0; f < 10; f++) begin
        int a = $urandom_range(0, 47);
        fetch(a);
        checks++; if (instruction !== expect_word(a) || addr_fault !== (a >= DEPTH) || instr_valid !== 1'b1)
          $display("FAIL rand_fetch_%0d: got %h/%b/%b want %h/%b/1", a, instruction, addr_fault, instr_valid, expect_word(a), a >= DEPTH);
        else passed++;
        checks++; if (parity_err !== 1'b0) $display("FAIL rand_perr_%0d: got %b want 0", a, parity_err); else passed++;
      end
    end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    logic [DEPTH-1:0] pb;
    pb = dut.par_bits;
    force dut.par_bits = pb ^ DEPTH'(4);
    fetch(2);
    checks++; if (parity_err !== 1'b1) $display("FAIL parity_bad: got %b want 1", parity_err); else passed++;
    fetch(3);
    checks++; if (parity_err !== 1'b0) $display("FAIL parity_good: got %b want 0", parity_err); else passed++;
    release dut.par_bits;
  endtask
`endif

  initial begin
    test_reset();
    test_fill_fetch();
    test_load_short();
    test_full_load();
    test_out_of_range();
    test_reset_mid_load();
    test_random();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/prog_instruction_memory.md
PROG_INSTRUCTION_MEMORY -- requirements
Module: prog_instruction_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width of the read and load ports.
REQ-003 SHALL have parameter DEPTH, default 32, number of stored words (DEPTH <= 2**ADDR_WIDTH).
REQ-004 SHALL have parameter FILL_WORD, default 8'hC0 ("j +0"), value of every word after reset and of any out-of-range read.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port Read_Address, input, ADDR_WIDTH, fetch address.
REQ-008 SHALL have port rd_en, input, 1, fetch request.
REQ-009 SHALL have port instruction, output, DATA_WIDTH, registered fetch data.
REQ-010 SHALL have port instr_valid, output, 1, instruction holds data from a completed fetch.
REQ-011 SHALL have port addr_fault, output, 1, last fetch was out of range (address >= DEPTH).
REQ-012 SHALL have port load_start, input, 1, one-cycle pulse that enters LOAD mode.
REQ-013 SHALL have port load_valid, input, 1, load_data is present.
REQ-014 SHALL have port load_data, input, DATA_WIDTH, word to store.
REQ-015 SHALL have port load_ready, output, 1, block accepts load_data this cycle.
REQ-016 SHALL have port load_done, input, 1, ends LOAD mode early.
REQ-017 SHALL have port load_count, output, ADDR_WIDTH+1, number of words written in the current or last load.
REQ-018 SHALL have port parity_err, output, 1, parity mismatch on the last fetch (see Configuration).

Function
REQ-019 SHALL implement two states: RUN (fetch enabled) and LOAD (sequential programming).
REQ-020 In RUN, SHALL register mem[Read_Address] into instruction one cycle after rd_en=1, with instr_valid=1 in that cycle.
REQ-021 In RUN with rd_en=0, SHALL hold instruction and clear instr_valid to 0.
REQ-022 A fetch with Read_Address >= DEPTH SHALL return FILL_WORD with instr_valid=1 and addr_fault=1; an in-range fetch SHALL clear addr_fault.
REQ-023 load_start in RUN SHALL move the block to LOAD on the next edge and clear the write pointer and load_count to 0.
REQ-024 In LOAD, load_ready SHALL be 1; each cycle with load_valid=1 SHALL write load_data to mem[pointer], then increment pointer and load_count.
REQ-025 The write that fills address DEPTH-1 SHALL return the block to RUN on the same edge; the pointer SHALL NOT wrap.
REQ-026 load_done in LOAD SHALL return the block to RUN; if load_valid=1 in the same cycle, that word SHALL be written first.
REQ-027 In LOAD, fetches SHALL be ignored: instr_valid=0 and instruction held.
REQ-028 load_start in LOAD SHALL be ignored; load_ready SHALL be 0 in RUN.
REQ-029 Unwritten words SHALL keep their previous contents (FILL_WORD after reset).

Reset
REQ-030 rst_n=0 SHALL immediately set state=RUN, instruction=FILL_WORD, instr_valid=0, addr_fault=0, parity_err=0, load_count=0, pointer=0, and every word to FILL_WORD.
REQ-031 Reset asserted mid-LOAD SHALL discard the partial load, leaving all words FILL_WORD.

Configuration
REQ-032 With IMEM_PARITY_EN defined, SHALL store an even-parity bit per word on load (FILL_WORD stored with correct parity) and set parity_err=1 with the fetch whose stored parity mismatches.
REQ-033 Without IMEM_PARITY_EN, SHALL store no parity bits and tie parity_err to 0.

Verification
REQ-034 Reset, then rd_en=1 on Read_Address=5 -> next cycle instruction=8'hC0, instr_valid=1, addr_fault=0.
REQ-035 load_start, then 4 beats 8'h49, 8'hC1, 8'h18, 8'hA9, then load_done; fetch addresses 0..3 -> 8'h49, 8'hC1, 8'h18, 8'hA9, load_count=4.
REQ-036 Load 32 consecutive words with load_valid held high -> 32nd write returns the block to RUN, load_ready=0, load_count=32, address 31 holds the 32nd word.
REQ-037 rd_en=1 on Read_Address=40 -> instruction=8'hC0, addr_fault=1; next fetch at address 0 -> addr_fault=0.
REQ-038 rst_n low after 3 load beats -> all words 8'hC0, state RUN, load_count=0.
REQ-039 With IMEM_PARITY_EN, force a stored parity bit to invert at address 2, fetch 2 -> parity_err=1; fetch 3 -> parity_err=0.
